// File: rtl/dplca_pkg.sv
// Shared DPLCA encodings, widths and helpers for the TXOP claim tracker.
package dplca_pkg;

  localparam int unsigned TXOP_TBL_W = 256;
  localparam int unsigned ID_W       = 8;

  // PLCA RS rx_cmd / tx_cmd encodings
  typedef enum logic [1:0] {
    BEACON = 2'b00,
    COMMIT = 2'b01,
    NONE   = 2'b10
  } plca_cmd_e;

  typedef enum logic {
    FAIL = 1'b0,
    OK   = 1'b1
  } plca_status_e;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } dplca_ctl_e;

  // Status bundle presented to the DPLCA state diagram
  typedef struct packed {
    logic            upd;
    logic            new_age;
    logic [ID_W-1:0] txop_id;
    logic [ID_W-1:0] node_count;
  } txop_status_t;

  // v+1, saturating at all-ones
  function automatic logic [ID_W-1:0] sat_inc(input logic [ID_W-1:0] v);
    return (v == '1) ? v : v + ID_W'(1);
  endfunction

endpackage

// File: rtl/dplca_claim_bitmap.sv
// Two-bank TXOP claim bitmap: current and previous aging period, registered union.
module dplca_claim_bitmap
  import dplca_pkg::*;
#(
  parameter int unsigned MAX_ID = 255
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  set_en,
  input  logic [ID_W-1:0]       set_id,
  input  logic                  rollover,
  output logic [TXOP_TBL_W-1:0] claim_table
);

  logic [TXOP_TBL_W-1:0] cur_q;
  logic [TXOP_TBL_W-1:0] prev_q;
  logic [TXOP_TBL_W-1:0] set_vec;
  logic [TXOP_TBL_W-1:0] cur_set;
  logic [TXOP_TBL_W-1:0] cur_d;
  logic [TXOP_TBL_W-1:0] prev_d;

  // Next bank contents; a same-cycle claim lands before the rollover copy
  always_comb begin
    set_vec = '0;
    if (set_en && (32'(set_id) <= MAX_ID)) begin
      set_vec[set_id] = 1'b1;
    end
    cur_set = cur_q | set_vec;
    cur_d   = rollover ? '0 : cur_set;
    prev_d  = rollover ? cur_set : prev_q;
  end

  // Bank registers and the registered union seen by the state diagram
  always_ff @(posedge clk) begin
    if (clr) begin
      cur_q       <= '0;
      prev_q      <= '0;
      claim_table <= '0;
    end else begin
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      claim_table <= cur_d | prev_d;
    end
  end

endmodule

// File: rtl/dplca_txop_table.sv
// DPLCA TXOP claim tracker: beacon edge detect, TXOP/aging counters, output registers.
module dplca_txop_table
  import dplca_pkg::*;
#(
  parameter int unsigned MAX_ID = 255,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  plca_reset,
  input  logic                  dplca_aging,
  input  logic [1:0]            rx_cmd,
  input  logic                  txop_end,
  input  logic [ID_W-1:0]       cur_id,
  input  logic                  txop_claimed,
  input  logic [CNT_W-1:0]      aging_cycles,
  output logic                  dplca_txop_table_upd,
  output logic                  dplca_new_age,
  output logic [ID_W-1:0]       dplca_txop_id,
  output logic [ID_W-1:0]       dplca_txop_node_count,
  output logic [TXOP_TBL_W-1:0] txop_claim_table
);

  localparam int unsigned AGE_W = CNT_W + 1;

  logic               clr;
  logic               bcn_prev_q;
  logic               beacon_edge;
  logic               rollover;
  logic [ID_W-1:0]    end_cnt;
  logic [ID_W-1:0]    txop_cnt_q;
  logic [ID_W-1:0]    txop_cnt_d;
  logic [CNT_W-1:0]   age_cnt_q;
  logic [CNT_W-1:0]   age_cnt_d;
  logic [AGE_W-1:0]   age_next;
  logic [AGE_W-1:0]   age_limit;
  txop_status_t       stat_q;
  txop_status_t       stat_d;

  assign clr = plca_reset | ~dplca_aging;

  // Event decode and next-state for counters and status outputs
  always_comb begin
    beacon_edge = (rx_cmd == BEACON) && !bcn_prev_q;
    end_cnt     = sat_inc(cur_id);
    age_next    = {1'b0, age_cnt_q} + AGE_W'(1);
    age_limit   = (aging_cycles == '0) ? AGE_W'(1) : {1'b0, aging_cycles};
    rollover    = beacon_edge && (age_next >= age_limit);

    txop_cnt_d  = txop_cnt_q;
    age_cnt_d   = age_cnt_q;
    stat_d      = stat_q;
    stat_d.upd  = beacon_edge | txop_end;

    if (beacon_edge) begin
      txop_cnt_d        = '0;
      stat_d.txop_id    = '0;
      stat_d.node_count = txop_end ? end_cnt : txop_cnt_q;
      age_cnt_d         = rollover ? '0 : age_next[CNT_W-1:0];
    end else if (txop_end) begin
      txop_cnt_d     = end_cnt;
      stat_d.txop_id = cur_id;
    end

    if (rollover) begin
      stat_d.new_age = 1'b1;
    end else if (beacon_edge || txop_end) begin
      stat_d.new_age = 1'b0;
    end
  end

  // State and output registers; reset or aging-off clears everything
  always_ff @(posedge clk) begin
    if (clr) begin
      bcn_prev_q <= 1'b0;
      txop_cnt_q <= '0;
      age_cnt_q  <= '0;
      stat_q     <= '0;
    end else begin
      bcn_prev_q <= (rx_cmd == BEACON);
      txop_cnt_q <= txop_cnt_d;
      age_cnt_q  <= age_cnt_d;
      stat_q     <= stat_d;
    end
  end

  dplca_claim_bitmap #(
    .MAX_ID (MAX_ID)
  ) u_bitmap (
    .clk         (clk),
    .clr         (clr),
    .set_en      (txop_end & txop_claimed),
    .set_id      (cur_id),
    .rollover    (rollover),
    .claim_table (txop_claim_table)
  );

  assign dplca_txop_table_upd  = stat_q.upd;
  assign dplca_new_age         = stat_q.new_age;
  assign dplca_txop_id         = stat_q.txop_id;
  assign dplca_txop_node_count = stat_q.node_count;

endmodule
